// File: rtl/lmsm_pkg.sv
// -----------------------------------------------------------------------------
// lmsm_pkg
// Shared definitions for the LM/SM sequencer:
//   - memory command encodings driven on mem_rw
//   - FSM state encodings
//   - register-index width (8-entry register file -> 3-bit index)
// -----------------------------------------------------------------------------
package lmsm_pkg;

  localparam int IDX_W = 3;

  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_WR   = 2'b01;
  localparam logic [1:0] MEM_RD   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lmsm_sequencer_lsb_prienc8.sv
// -----------------------------------------------------------------------------
// lsb_prienc8
// 8-bit lowest-set-bit priority encoder. Bit 0 has the highest priority.
// Ports:
//   vec_i   in  8  request vector
//   idx_o   out 3  index of the lowest set bit (0 when vec_i is 0)
//   valid_o out 1  high when any bit of vec_i is set
// -----------------------------------------------------------------------------
module lsb_prienc8
  import lmsm_pkg::*;
(
  input  logic [7:0]       vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
// Multi-cycle LM (load multiple) / SM (store multiple) sequencer. Walks the
// latched register list lowest-index first, moving one word per cycle between
// the register file and consecutive memory words starting at base_addr.
//
// Optional build macro: LMSM_ADDR_ERR_EN
//   Adds output addr_err. Transfers whose pointer lies above the memory range
//   are suppressed (still consume a cycle and a list bit) and set addr_err,
//   which is sticky until the next accepted start. Without the macro the
//   memory address silently wraps on the low ADDR_W pointer bits.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin an operation (sampled in IDLE only)
//   is_sm             0 = LM (mem -> regs), 1 = SM (regs -> mem)
//   reg_list          participating registers, bit i = Ri
//   base_addr         first memory address
//   mem_rdata         combinational memory read data
//   rf_rdata          combinational register read data for rf_raddr
//   mem_addr/rw/wdata memory command (rw: 00 idle, 01 write, 10 read)
//   rf_raddr          register read index (SM)
//   rf_waddr/wdata/we register write port (LM)
//   busy              high in XFER and DONE
//   done              one-cycle completion pulse
//   addr_err          (macro only) sticky out-of-range flag
// -----------------------------------------------------------------------------
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_sm,
  input  logic [NREG-1:0]   reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [IDX_W-1:0]  rf_raddr,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              busy,
  output logic              done
`ifdef LMSM_ADDR_ERR_EN
  ,
  output logic              addr_err
`endif
);

  state_t            state_q, state_d;
  logic              is_sm_q, is_sm_d;
  logic [NREG-1:0]   rem_list_q, rem_list_d;
  logic [DATA_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0]  idx;
  logic              idx_valid;
  logic [NREG-1:0]   rem_cleared;
  logic              in_range;
  logic              xfer_go;

  lsb_prienc8 u_prienc (
    .vec_i   (rem_list_q),
    .idx_o   (idx),
    .valid_o (idx_valid)
  );

  assign rem_cleared = rem_list_q & ~(NREG'(1) << idx);

`ifdef LMSM_ADDR_ERR_EN
  logic addr_err_q, addr_err_d;
  assign in_range = ~|ptr_q[DATA_W-1:ADDR_W];
  assign addr_err = addr_err_q;
`else
  assign in_range = 1'b1;
`endif

  // A transfer is driven only while rst_n is high, so a reset asserted during
  // XFER blocks the write that would otherwise land on the reset edge.
  assign xfer_go = (state_q == ST_XFER) && idx_valid && in_range && rst_n;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_sm_q    <= 1'b0;
      rem_list_q <= '0;
      ptr_q      <= '0;
`ifdef LMSM_ADDR_ERR_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_sm_q    <= is_sm_d;
      rem_list_q <= rem_list_d;
      ptr_q      <= ptr_d;
`ifdef LMSM_ADDR_ERR_EN
      addr_err_q <= addr_err_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    is_sm_d    = is_sm_q;
    rem_list_d = rem_list_q;
    ptr_d      = ptr_q;
`ifdef LMSM_ADDR_ERR_EN
    addr_err_d = addr_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_sm_d    = is_sm;
          rem_list_d = reg_list;
          ptr_d      = base_addr;
`ifdef LMSM_ADDR_ERR_EN
          addr_err_d = 1'b0;
`endif
          state_d    = (reg_list != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        rem_list_d = rem_cleared;
        ptr_d      = ptr_q + DATA_W'(1);
`ifdef LMSM_ADDR_ERR_EN
        if (!in_range) addr_err_d = 1'b1;
`endif
        if (rem_cleared == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_addr  = '0;
    mem_rw    = MEM_IDLE;
    mem_wdata = '0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    busy      = (state_q == ST_XFER) || (state_q == ST_DONE);
    done      = (state_q == ST_DONE);
    if (xfer_go) begin
      mem_addr = ptr_q[ADDR_W-1:0];
      if (is_sm_q) begin
        rf_raddr  = idx;
        mem_rw    = MEM_WR;
        mem_wdata = rf_rdata;
      end else begin
        mem_rw   = MEM_RD;
        rf_we    = 1'b1;
        rf_waddr = idx;
        rf_wdata = mem_rdata;
      end
    end
  end

endmodule
